issue_sched: RTL
================

# issue_sched

Parametrised in-order issue scheduler. It is the successor to the fixed 4-wide, 3-unit issue stage. Each cycle it examines a WINDOW-entry head-of-queue window and assigns ready instructions, strictly in order, to PORTS execution ports according to per-port class masks. Each port has a registered output stage with valid/ready handshake. The block sits between the instruction queue/operand-lookup logic and the execution units (ALU, MULDIV, LS, branch).

## Interface
Parameters:
- WINDOW, 4: number of window entries examined per cycle (2..8).
- PORTS, 4: number of execution ports (1..8).
- DATA_W, 32: operand width.
- ROB_IDX_W, 4: ROB slot index width.
- INSN_W, 64: opaque decoded-instruction payload width.
- PORT_CLASS, 16'b0011_0001_0100_1000: PORTS×4 bits; PORT_CLASS[p*4+:4] is the class mask of port p. Class bits are: bit0 ALU, bit1 MULDIV, bit2 LS, bit3 BRANCH. Default mapping: p0 BRANCH, p1 LS, p2 ALU, p3 ALU|MULDIV.

Ports:
- clock  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all port registers; issue nothing this cycle.
- win_valid  in  WINDOW  entry i valid (entry 0 = oldest).
- win_class  in  WINDOW×4  one-hot class per entry.
- win_ops_ready  in  WINDOW  all required operands of entry i available.
- win_a, win_b  in  WINDOW×DATA_W  operand values.
- win_slot  in  WINDOW×ROB_IDX_W  ROB slot per entry.
- win_insn  in  WINDOW×INSN_W  decoded payload per entry.
- consumed  out  $clog2(WINDOW+1)  entries removed from the window head this cycle (combinational).
- port_valid  out  PORTS  port p holds an instruction.
- port_ready  in  PORTS  execution unit p accepts this cycle.
- port_a, port_b  out  PORTS×DATA_W  registered operands.
- port_slot  out  PORTS×ROB_IDX_W  registered ROB slot.
- port_insn  out  PORTS×INSN_W  registered payload.
- stall_cycles  out  16  saturating count of head-blocked cycles.

## Operation
- Port p is free this cycle when ~port_valid[p] | port_ready[p].
- Selection scans i = 0..WINDOW-1 in order:
  - Stop at the first entry that is invalid, not ops-ready, or has a zero or multi-hot class.
  - Entry i claims the lowest-index free, unclaimed port whose PORT_CLASS mask contains the entry's class. If no such port exists, stop.
  - A BRANCH entry additionally requires i < WINDOW-1 and win_valid[i+1] (delay slot present). Otherwise stop. The delay-slot entry is scanned normally afterwards.
- consumed = number of entries claimed before the stop. At most one entry claims any given port per cycle.
- Port register update, per port:
  - Claimed: load a/b/slot/insn and set port_valid.
  - Else, if port_ready[p]: clear port_valid.
  - Else: hold all fields.
- flush: consumed = 0 and all port_valid clear next edge. Flush takes priority over claim and hold.
- stall_cycles increments, saturating at 16'hFFFF, when win_valid[0] & consumed==0 & ~flush. It is cleared only by reset.
- Reset: all port_valid = 0, port_a/b/slot/insn = 0, stall_cycles = 0. consumed evaluates to 0 while reset is high.

## Timing
- Issue latency: an instruction is claimed in cycle N and appears on port_valid/port_* in cycle N+1.
- Back-to-back issue to the same port is allowed when port_ready is high in the claim cycle, giving full throughput of one instruction per port per cycle.
- port_* fields are stable while port_valid & ~port_ready.
- consumed is combinational from win_* and port_valid/port_ready. The upstream queue pops consumed entries on the same edge.
- Flush asserted in the same cycle as port_ready=1: the port clears and nothing is reloaded.
- Reset asserted mid-operation: everything clears on the next edge regardless of flush or ready.

## Test plan
- Window {ALU, LS, ALU, MULDIV}, all valid and ready, all ports empty, default PORT_CLASS -> consumed=3 (ALU→p2, LS→p1, ALU→p3). MULDIV stops the scan because p3 is claimed. port_valid=4'b1110 next cycle.
- Window {BRANCH, ALU, -, -} with win_valid=4'b0011 -> consumed=2, branch to p0, ALU to p2. Repeat with win_valid=4'b0001 -> consumed=0 and stall_cycles increments by 1.
- Window {ALU, ALU(ops not ready), ALU, -} -> consumed=1. Entry 2 is not issued even though p3 is free (in-order).
- Hold p2 with port_ready[2]=0 for 3 cycles while port_a=32'hDEADBEEF -> value stable for 3 cycles. Window ALU then goes to p3. Raise port_ready[2] -> p2 reloads on the same edge with the next ALU.
- flush in a cycle with 4 issuable entries -> consumed=0, port_valid=0 next cycle. Assert reset mid-stream -> all outputs 0 next cycle.
- Force stall for 70000 cycles -> stall_cycles saturates at 16'hFFFF. Rerun with WINDOW=8, PORTS=2 and an all-ALU mask -> consumed caps at 2 per cycle.

Source files
------------

// File: rtl/issue_sched.sv
// In-order issue scheduler: scans a head-of-queue window and dispatches ready
// instructions to class-matched execution ports with registered valid/ready outputs.
module issue_sched #(
  parameter int WINDOW    = 4,
  parameter int PORTS     = 4,
  parameter int DATA_W    = 32,
  parameter int ROB_IDX_W = 4,
  parameter int INSN_W    = 64,
  parameter logic [PORTS*4-1:0] PORT_CLASS = 16'b0011_0001_0100_1000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [WINDOW-1:0]             win_valid,
  input  logic [WINDOW*4-1:0]           win_class,
  input  logic [WINDOW-1:0]             win_ops_ready,
  input  logic [WINDOW*DATA_W-1:0]      win_a,
  input  logic [WINDOW*DATA_W-1:0]      win_b,
  input  logic [WINDOW*ROB_IDX_W-1:0]   win_slot,
  input  logic [WINDOW*INSN_W-1:0]      win_insn,
  output logic [$clog2(WINDOW+1)-1:0]   consumed,
  output logic [PORTS-1:0]              port_valid,
  input  logic [PORTS-1:0]              port_ready,
  output logic [PORTS*DATA_W-1:0]       port_a,
  output logic [PORTS*DATA_W-1:0]       port_b,
  output logic [PORTS*ROB_IDX_W-1:0]    port_slot,
  output logic [PORTS*INSN_W-1:0]       port_insn,
  output logic [15:0]                   stall_cycles
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int IDX_W = $clog2(WINDOW);

  logic [PORTS-1:0]  free;
  logic [PORTS-1:0]  claim;
  logic [IDX_W-1:0]  src [PORTS];
  logic [WINDOW-1:0] next_valid;
  logic              stop;
  logic              found;
  logic [3:0]        cls;

  assign free       = ~port_valid | port_ready;
  // next_valid[i] is win_valid[i+1]; the top entry never has a delay slot.
  assign next_valid = {1'b0, win_valid[WINDOW-1:1]};

  // NOTE: every variable gets a default at the top so no path leaves a latch;
  // blocking assignments here are intentional, later iterations see earlier claims.
  always_comb begin
    claim    = '0;
    consumed = '0;
    stop     = reset | flush;
    found    = 1'b0;
    cls      = '0;
    for (int p = 0; p < PORTS; p++) src[p] = '0;
    for (int i = 0; i < WINDOW; i++) begin
      cls = win_class[i*4 +: 4];
      if (!stop) begin
        if (!win_valid[i] || !win_ops_ready[i] || cls == 4'd0 ||
            (cls & (cls - 4'd1)) != 4'd0) begin
          stop = 1'b1;
        end else if (cls[3] && !next_valid[i]) begin
          stop = 1'b1;
        end else begin
          found = 1'b0;
          for (int p = 0; p < PORTS; p++) begin
            if (!found && free[p] && !claim[p] && (PORT_CLASS[p*4 +: 4] & cls) != 4'd0) begin
              claim[p] = 1'b1;
              src[p]   = IDX_W'(i);
              found    = 1'b1;
            end
          end
          if (found) consumed = consumed + CNT_W'(1);
          else       stop     = 1'b1;
        end
      end
    end
  end

  // NOTE: payload registers are reset too, because the ports must read zero
  // after reset; sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (reset) begin
      port_valid <= '0;
      port_a     <= '0;
      port_b     <= '0;
      port_slot  <= '0;
      port_insn  <= '0;
    end else begin
      for (int p = 0; p < PORTS; p++) begin
        if (flush) begin
          port_valid[p] <= 1'b0;
        end else if (claim[p]) begin
          port_valid[p]                       <= 1'b1;
          port_a[p*DATA_W +: DATA_W]          <= win_a[src[p]*DATA_W +: DATA_W];
          port_b[p*DATA_W +: DATA_W]          <= win_b[src[p]*DATA_W +: DATA_W];
          port_slot[p*ROB_IDX_W +: ROB_IDX_W] <= win_slot[src[p]*ROB_IDX_W +: ROB_IDX_W];
          port_insn[p*INSN_W +: INSN_W]       <= win_insn[src[p]*INSN_W +: INSN_W];
        end else if (port_ready[p]) begin
          port_valid[p] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (win_valid[0] && consumed == '0 && !flush && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
